// File: rtl/serial_cpu_8bit_if.sv
// Byte-wide SRAM bus between the CPU and the shared 512x8 SRAM.
// The CPU drives the address/control side (master); the memory/top-level
// mux drives the read-data side (slave). There is no ready: the SRAM
// always answers one cycle after an access, so enable alone qualifies a
// request and the is_i_addr select decides which address/data pair is live.
interface serial_cpu_8bit_if;
    logic       enable;
    logic       is_i_addr;
    logic [8:0] i_addr;
    logic [7:0] i_datain;
    logic [8:0] d_addr;
    logic [7:0] d_datain;
    logic       d_we;
    logic [7:0] d_dataout;

    modport master (
        output enable, is_i_addr, i_addr, d_addr, d_we, d_dataout,
        input  i_datain, d_datain
    );

    modport slave (
        input  enable, is_i_addr, i_addr, d_addr, d_we, d_dataout,
        output i_datain, d_datain
    );
endinterface

// File: rtl/serial_cpu_8bit.sv
// Multi-cycle CPU with 16-bit instructions and eight 16-bit registers.
// Every 16-bit word moves as two byte accesses (low at 2*addr, high at
// 2*addr+1) over a shared byte SRAM with one cycle of read latency.
module serial_cpu_8bit #(
    parameter int DEFAULT_PC_ADDR = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               nxt,
    serial_cpu_8bit_if.master  bus,
    output logic [3:0]         dbg_state,
    output logic [7:0]         dbg_pc,
    output logic [2:0]         dbg_flags   // {Z, N, C}
);
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,  S_F0 = 4'd1,  S_F1 = 4'd2,  S_F2 = 4'd3,
        S_EX   = 4'd4,  S_M0 = 4'd5,  S_M1 = 4'd6,  S_M2 = 4'd7,
        S_WB   = 4'd8,  S_S0 = 4'd9,  S_S1 = 4'd10, S_HALT = 4'd11
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'b00000, OP_HALT = 5'b00001;
    localparam logic [4:0] OP_LOAD = 5'b00010, OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL  = 5'b00100, OP_SRL  = 5'b00110;
    localparam logic [4:0] OP_ADD  = 5'b01000, OP_ADDI = 5'b01001;
    localparam logic [4:0] OP_SUB  = 5'b01010, OP_SUBI = 5'b01011;
    localparam logic [4:0] OP_CMP  = 5'b01100, OP_AND  = 5'b01101;
    localparam logic [4:0] OP_OR   = 5'b01110, OP_XOR  = 5'b01111;
    localparam logic [4:0] OP_SET  = 5'b10100, OP_JUMP = 5'b11000;
    localparam logic [4:0] OP_BZ   = 5'b11010, OP_BNZ  = 5'b11011;
    localparam logic [4:0] OP_BN   = 5'b11100, OP_BNN  = 5'b11101;
    localparam logic [4:0] OP_BC   = 5'b11110, OP_BNC  = 5'b11111;

    localparam logic [7:0] PC_START = 8'(DEFAULT_PC_ADDR);

    state_t      state, next_state;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [15:0] dword;
    logic [15:0] regs [8];
    logic        flag_z, flag_n, flag_c;

    // Instruction fields
    logic [4:0]  op;
    logic [2:0]  r1, r2, r3;
    logic [3:0]  val3;
    logic [7:0]  imm;
    logic [15:0] a1, a2, a3;
    logic [7:0]  ea;

    assign op   = ir[15:11];
    assign r1   = ir[10:8];
    assign r2   = ir[6:4];
    assign r3   = ir[2:0];
    assign val3 = ir[3:0];
    assign imm  = ir[7:0];
    assign a1   = regs[r1];
    assign a2   = regs[r2];
    assign a3   = regs[r3];
    // Registers do not change during M*/S* states, so ea can stay combinational.
    assign ea   = a2[7:0] + {4'd0, val3};

    // Execute-stage results, consumed by the datapath register at the end of EX
    logic [16:0] alu_res;
    logic        alu_wr, flag_wr, br_taken;
    logic [7:0]  br_target;

    // Decode and compute ALU result, flag update and branch decision
    always_comb begin
        alu_res   = '0;
        alu_wr    = 1'b0;
        flag_wr   = 1'b0;
        br_taken  = 1'b0;
        br_target = a1[7:0] + imm;
        case (op)
            OP_ADD:  begin alu_res = {1'b0, a2} + {1'b0, a3};       alu_wr = 1'b1; flag_wr = 1'b1; end
            OP_ADDI: begin alu_res = {1'b0, a1} + {9'd0, imm};      alu_wr = 1'b1; flag_wr = 1'b1; end
            OP_SUB:  begin alu_res = {1'b0, a2} - {1'b0, a3};       alu_wr = 1'b1; flag_wr = 1'b1; end
            OP_SUBI: begin alu_res = {1'b0, a1} - {9'd0, imm};      alu_wr = 1'b1; flag_wr = 1'b1; end
            OP_CMP:  begin alu_res = {1'b0, a2} - {1'b0, a3};                      flag_wr = 1'b1; end
            OP_AND:  begin alu_res = {1'b0, a2 & a3};               alu_wr = 1'b1; flag_wr = 1'b1; end
            OP_OR:   begin alu_res = {1'b0, a2 | a3};               alu_wr = 1'b1; flag_wr = 1'b1; end
            OP_XOR:  begin alu_res = {1'b0, a2 ^ a3};               alu_wr = 1'b1; flag_wr = 1'b1; end
            OP_SLL:  begin alu_res = {1'b0, a2 << val3};            alu_wr = 1'b1; flag_wr = 1'b1; end
            OP_SRL:  begin alu_res = {1'b0, a2 >> val3};            alu_wr = 1'b1; flag_wr = 1'b1; end
            OP_SET:  begin alu_res = {9'd0, imm};                   alu_wr = 1'b1; end
            OP_JUMP: begin br_taken = 1'b1; br_target = imm; end
            OP_BZ:   br_taken = flag_z;
            OP_BNZ:  br_taken = !flag_z;
            OP_BN:   br_taken = flag_n;
            OP_BNN:  br_taken = !flag_n;
            OP_BC:   br_taken = flag_c;
            OP_BNC:  br_taken = !flag_c;
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic; start only matters when idle or halted
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_HALT: if (start) next_state = S_F0;
            S_F0: next_state = S_F1;
            S_F1: next_state = S_F2;
            S_F2: next_state = S_EX;
            S_EX: begin
                case (op)
                    OP_HALT:  next_state = S_HALT;
                    OP_LOAD:  next_state = S_M0;
                    OP_STORE: next_state = S_S0;
                    default:  next_state = S_F0;
                endcase
            end
            S_M0: next_state = S_M1;
            S_M1: next_state = S_M2;
            S_M2: next_state = S_WB;
            S_WB: next_state = S_F0;
            S_S0: next_state = S_S1;
            S_S1: next_state = S_F0;
            default: next_state = S_IDLE;
        endcase
    end

    // Bus outputs decoded purely from state so reset removes d_we at once
    always_comb begin
        bus.enable    = 1'b0;
        bus.is_i_addr = 1'b1;
        bus.i_addr    = '0;
        bus.d_addr    = '0;
        bus.d_we      = 1'b0;
        bus.d_dataout = '0;
        nxt           = 1'b0;
        case (state)
            S_F0:       begin bus.enable = 1'b1; bus.i_addr = {pc, 1'b0}; end
            S_F1, S_F2: begin bus.enable = 1'b1; bus.i_addr = {pc, 1'b1}; end
            S_EX, S_WB: bus.enable = 1'b1;
            S_M0:       begin bus.enable = 1'b1; bus.is_i_addr = 1'b0; bus.d_addr = {ea, 1'b0}; end
            S_M1, S_M2: begin bus.enable = 1'b1; bus.is_i_addr = 1'b0; bus.d_addr = {ea, 1'b1}; end
            S_S0: begin
                bus.enable = 1'b1; bus.is_i_addr = 1'b0;
                bus.d_addr = {ea, 1'b0}; bus.d_we = 1'b1; bus.d_dataout = a1[7:0];
            end
            S_S1: begin
                bus.enable = 1'b1; bus.is_i_addr = 1'b0;
                bus.d_addr = {ea, 1'b1}; bus.d_we = 1'b1; bus.d_dataout = a1[15:8];
            end
            S_HALT: nxt = 1'b1;
            default: ;
        endcase
    end

    // Datapath: PC, instruction latch, load buffer, register file and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= '0;
            ir     <= '0;
            dword  <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: if (start) pc <= PC_START;
                S_F1: ir[7:0]  <= bus.i_datain;
                S_F2: ir[15:8] <= bus.i_datain;
                S_EX: begin
                    pc <= br_taken ? br_target : pc + 8'd1;
                    if (alu_wr) regs[r1] <= alu_res[15:0];
                    if (flag_wr) begin
                        flag_z <= (alu_res[15:0] == 16'd0);
                        flag_n <= alu_res[15];
                        flag_c <= alu_res[16];
                    end
                end
                S_M1: dword[7:0]  <= bus.d_datain;
                S_M2: dword[15:8] <= bus.d_datain;
                S_WB: regs[r1] <= dword;
                default: ;
            endcase
        end
    end

    assign dbg_state = state;
    assign dbg_pc    = pc;
    assign dbg_flags = {flag_z, flag_n, flag_c};
endmodule

// File: tb/tb_serial_cpu_8bit.sv
// Directed bench for serial_cpu_8bit: small programs in a behavioural
// 512x8 SRAM with one cycle of read latency, hand-computed expectations.
module tb_serial_cpu_8bit;
    localparam logic [3:0] ST_IDLE = 4'd0, ST_F0 = 4'd1, ST_HALT = 4'd11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic nxt;
    logic [3:0] dbg_state;
    logic [7:0] dbg_pc;
    logic [2:0] dbg_flags;

    serial_cpu_8bit_if bus ();

    serial_cpu_8bit #(.DEFAULT_PC_ADDR(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .nxt(nxt), .bus(bus),
        .dbg_state(dbg_state), .dbg_pc(dbg_pc), .dbg_flags(dbg_flags)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- SRAM model ----------------
    logic [7:0] mem [512];
    logic [7:0] sram_q = '0;
    assign bus.i_datain = sram_q;
    assign bus.d_datain = sram_q;

    always @(posedge clk) begin
        if (bus.enable) begin
            if (bus.is_i_addr)   sram_q <= mem[bus.i_addr];
            else if (bus.d_we)   mem[bus.d_addr] = bus.d_dataout;
            else                 sram_q <= mem[bus.d_addr];
        end
    end

    // ---------------- monitors ----------------
    int we_count = 0;
    logic [8:0] fetch_q[$];
    always @(negedge clk) begin
        if (bus.d_we) we_count++;
        if (dbg_state == ST_F0) fetch_q.push_back(bus.i_addr);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [8:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    endtask

    task automatic put_word(input int w, input logic [15:0] v);
        mem[2*w]   = v[7:0];
        mem[2*w+1] = v[15:8];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Leaves the caller at the negedge just after the edge that sampled start
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_nxt(input string tag, input int budget);
        int n = 0;
        while (nxt !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'd0, nxt}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_mem();

        // Reset state while rst_n is held low
        repeat (3) @(negedge clk);
        check_eq("rst_enable",    {31'd0, bus.enable},    32'd0);
        check_eq("rst_is_i_addr", {31'd0, bus.is_i_addr}, 32'd1);
        check_eq("rst_nxt",       {31'd0, nxt},           32'd0);
        check_eq("rst_i_addr",    {23'd0, bus.i_addr},    32'd0);
        check_eq("rst_d_addr",    {23'd0, bus.d_addr},    32'd0);
        check_eq("rst_d_we",      {31'd0, bus.d_we},      32'd0);
        check_eq("rst_d_dataout", {24'd0, bus.d_dataout}, 32'd0);
        check_eq("rst_state",     {28'd0, dbg_state},     {28'd0, ST_IDLE});
        check_eq("rst_pc",        {24'd0, dbg_pc},        32'd0);
        check_eq("rst_flags",     {29'd0, dbg_flags},     32'd0);
        rst_n = 1'b1;

        // HALT at word 16
        put_word(16, 16'h0800);
        do_reset();
        pulse_start();                                             // cycle 1: F0
        check_eq("halt_f0_addr",  {23'd0, bus.i_addr}, 32'h20);
        check_eq("halt_f0_en",    {31'd0, bus.enable}, 32'd1);
        @(negedge clk);                                            // cycle 2: F1
        check_eq("halt_f1_addr",  {23'd0, bus.i_addr}, 32'h21);
        repeat (3) @(negedge clk);                                 // cycle 5: HALT
        check_eq("halt_nxt_c5",   {31'd0, nxt},        32'd1);
        check_eq("halt_en_off",   {31'd0, bus.enable}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("halt_nxt_hold", {31'd0, nxt},        32'd1);
        pulse_start();                                             // restart from HALT
        check_eq("restart_nxt",   {31'd0, nxt},        32'd0);
        check_eq("restart_addr",  {23'd0, bus.i_addr}, 32'h20);
        wait_nxt("restart_halt", 20);

        // Sum loop: 4+3+2+1 stored at word 2
        clear_mem();
        put_word(16, 16'hA304);   // SET  gr3,4
        put_word(17, 16'hA100);   // SET  gr1,0
        put_word(18, 16'h4113);   // ADD  gr1,gr1,gr3
        put_word(19, 16'h5B01);   // SUBI gr3,1
        put_word(20, 16'hD812);   // BNZ  gr0,0x12
        put_word(21, 16'h1902);   // STORE gr1,gr0,2
        put_word(22, 16'h0800);   // HALT
        do_reset();
        pulse_start();
        wait_nxt("sum_nxt", 180);
        check_eq("sum_byte4", {24'd0, mem[4]}, 32'h0A);
        check_eq("sum_byte5", {24'd0, mem[5]}, 32'h00);

        // LOAD then STORE copies a word
        clear_mem();
        mem[0] = 8'hAB;
        mem[1] = 8'h00;
        put_word(16, 16'h1200);   // LOAD  gr2,gr0,0
        put_word(17, 16'h1A01);   // STORE gr2,gr0,1
        put_word(18, 16'h0800);   // HALT
        do_reset();
        we_count = 0;
        pulse_start();
        wait_nxt("ls_nxt", 60);
        check_eq("ls_byte2",   {24'd0, mem[2]}, 32'hAB);
        check_eq("ls_byte3",   {24'd0, mem[3]}, 32'h00);
        check_eq("ls_we_cnt",  we_count,        32'd2);

        // Flags and branches, with start pulses mid-run that must be ignored
        clear_mem();
        put_word(16, 16'h6011);   // CMP   gr0,gr1,gr1   -> Z=1
        put_word(17, 16'hD020);   // BZ    gr0,0x20      -> taken to 32
        put_word(32, 16'hD805);   // BNZ   gr0,0x05      -> not taken, 33
        put_word(33, 16'hA501);   // SET   gr5,1
        put_word(34, 16'h5405);   // SUB   gr4,gr0,gr5   -> 0xFFFF, N=1 C=1
        put_word(35, 16'h1C03);   // STORE gr4,gr0,3
        put_word(36, 16'h0800);   // HALT
        do_reset();
        fetch_q.delete();
        exp_q = '{9'h020, 9'h022, 9'h040, 9'h042, 9'h044, 9'h046, 9'h048};
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        repeat (6) @(negedge clk);
        pulse_start();
        wait_nxt("br_nxt", 100);
        check_eq("br_fetch_cnt", fetch_q.size(), exp_q.size());
        while (exp_q.size() > 0 && fetch_q.size() > 0)
            check_eq("br_fetch_addr", {23'd0, fetch_q.pop_front()}, {23'd0, exp_q.pop_front()});
        check_eq("sub_flags_znc", {29'd0, dbg_flags}, 32'b011);
        check_eq("sub_byte6", {24'd0, mem[6]}, 32'hFF);
        check_eq("sub_byte7", {24'd0, mem[7]}, 32'hFF);

        // Reset asserted in the middle of a STORE
        clear_mem();
        put_word(16, 16'h1800);   // STORE gr0,gr0,0
        put_word(17, 16'h0800);   // HALT
        do_reset();
        pulse_start();
        begin
            int n = 0;
            while (bus.d_we !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check_eq("mid_store_we_seen", {31'd0, bus.d_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_we",     {31'd0, bus.d_we},      32'd0);
        check_eq("rst_mid_enable", {31'd0, bus.enable},    32'd0);
        check_eq("rst_mid_isi",    {31'd0, bus.is_i_addr}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_state", {28'd0, dbg_state},  {28'd0, ST_IDLE});
        check_eq("post_rst_en",    {31'd0, bus.enable}, 32'd0);
        check_eq("post_rst_nxt",   {31'd0, nxt},        32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
